// File: rtl/rv_mc_control.sv
// rv_mc_control: multicycle RV32I control unit.
// Moore FSM: state register, next-state logic and output decode are separate
// processes. A few outputs also depend on inputs: FETCH gates ir_write/pc_write
// with mem_ready, and BRANCH gates pc_write with the compare result.
// While reset is high, every output is forced to 0.
module rv_mc_control #(
  parameter int WAIT_MEM = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal
);

  // Encoding 4'd15 is unused. The next-state default case sends it back to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ready_s;
  logic   take_s;
  logic   branch_bad_s;

  // With WAIT_MEM=0, memory is treated as always ready, so every wait lasts one cycle.
  assign ready_s      = (WAIT_MEM != 0) ? mem_ready : 1'b1;
  // funct3 values 010 and 011 are not valid branch encodings.
  assign branch_bad_s = (funct3[2:1] == 2'b01);

  // Branch condition selected by funct3.
  always_comb begin
    take_s = 1'b0;
    case (funct3)
      3'b000:  take_s = zero;
      3'b001:  take_s = ~zero;
      3'b100:  take_s = lt;
      3'b101:  take_s = ~lt;
      3'b110:  take_s = ltu;
      3'b111:  take_s = ~ltu;
      default: take_s = 1'b0;
    endcase
  end

  // State register. A synchronous reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (ready_s) state_d = S_DECODE;
        else         state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          7'b0000011: state_d = S_MEMADR;
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111: state_d = S_JALR;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_ALUWB;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (opcode[5]) state_d = S_MEMWRITE;
        else           state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (ready_s) state_d = S_MEMWB;
        else         state_d = S_MEMREAD;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE: begin
        if (ready_s) state_d = S_FETCH;
        else         state_d = S_MEMWRITE;
      end
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH: begin
        if (branch_bad_s) state_d = S_TRAP;
        else              state_d = S_FETCH;
      end
      S_JAL:     state_d = S_ALUWB;
      S_JALR:    state_d = S_JLINK;
      S_JLINK:   state_d = S_ALUWB;
      S_LUI:     state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode from the current state. Outputs not set in a state stay 0.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    if (reset) begin
      illegal = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = ready_s;
          pc_write   = ready_s;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = take_s & ~branch_bad_s;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
        end
        S_JLINK: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_LUI: begin
          result_src = 2'b11;
          reg_write  = 1'b1;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_control.sv
// Directed testbench for rv_mc_control. Every output is packed into one vector,
// {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
//  alu_src_b, result_src, alu_op, illegal}, and compared each cycle with
// hand-written per-state constants.
module tb_rv_mc_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst0 = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b1;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0, illegal0;
  logic [1:0] alu_src_a0, alu_src_b0, result_src0, alu_op0;

  logic [14:0] obs, obs0;
  int tests = 0;
  int fails = 0;

  // Expected output vector for each state (FETCH is shown with mem_ready=1 and with mem_ready=0).
  localparam logic [14:0] E_FETCH1   = {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] E_FETCH0   = {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] E_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_MEMADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_MEMREAD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_MEMWB    = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] E_MEMWRITE = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] E_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] E_ALUWB    = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_JAL      = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_JALR     = {6'b000010, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] E_JLINK    = {6'b000000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] E_LUI      = {6'b000001, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0};
  localparam logic [14:0] E_TRAP     = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [14:0] E_ZERO     = 15'b0;

  function automatic logic [14:0] e_branch(input logic t);
    return {4'b0000, t, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
  endfunction

  rv_mc_control #(.WAIT_MEM(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .illegal(illegal)
  );

  rv_mc_control #(.WAIT_MEM(0)) dut0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(1'b0),
    .mem_req(mem_req0), .mem_write(mem_write0), .adr_src(adr_src0),
    .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .result_src(result_src0),
    .alu_op(alu_op0), .illegal(illegal0)
  );

  assign obs  = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_op, illegal};
  assign obs0 = {mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0,
                 alu_src_a0, alu_src_b0, result_src0, alu_op0, illegal0};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    #1;
    if (obs !== E_ZERO) begin $display("FAIL reset_outs: got %b want %b", obs, E_ZERO); fails++; end
    tests++;
    if (obs0 !== E_ZERO) begin $display("FAIL reset_outs_nowait: got %b want %b", obs0, E_ZERO); fails++; end
    tests++;
    reset = 1'b0;
    #1;
    if (obs !== E_FETCH1) begin $display("FAIL reset_release: got %b want %b", obs, E_FETCH1); fails++; end
    tests++;
  endtask

  task automatic test_add;
    logic [14:0] ev [5];
    ev = '{E_FETCH1, E_DECODE, E_EXECR, E_ALUWB, E_FETCH1};
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (obs !== ev[i]) begin $display("FAIL add cyc%0d: got %b want %b", i, obs, ev[i]); fails++; end
      tests++;
      tick();
    end
  endtask

  task automatic test_lw;
    logic [14:0] ev [10];
    logic        rdy [10];
    ev  = '{E_FETCH0, E_FETCH1, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD,
            E_MEMREAD, E_MEMREAD, E_MEMWB, E_FETCH1};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 7'b0000011;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      if (obs !== ev[i]) begin $display("FAIL lw cyc%0d: got %b want %b", i, obs, ev[i]); fails++; end
      tests++;
      tick();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_branch;
    logic [2:0] f3 [5];
    logic       tk [5];
    f3 = '{3'b000, 3'b001, 3'b110, 3'b100, 3'b111};
    tk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    zero = 1'b1; lt = 1'b0; ltu = 1'b1;
    mem_ready = 1'b1;
    opcode = 7'b1100011;
    for (int b = 0; b < 5; b++) begin
      logic [14:0] ev [4];
      ev = '{E_FETCH1, E_DECODE, e_branch(tk[b]), E_FETCH1};
      funct3 = f3[b];
      do_reset();
      for (int i = 0; i < 4; i++) begin
        #1;
        if (obs !== ev[i]) begin
          $display("FAIL branch f3=%b cyc%0d: got %b want %b", f3[b], i, obs, ev[i]); fails++;
        end
        tests++;
        tick();
      end
    end
    funct3 = 3'b010;
    do_reset();
    begin
      logic [14:0] ev [5];
      ev = '{E_FETCH1, E_DECODE, e_branch(1'b0), E_TRAP, E_TRAP};
      for (int i = 0; i < 5; i++) begin
        #1;
        if (obs !== ev[i]) begin $display("FAIL branch_bad cyc%0d: got %b want %b", i, obs, ev[i]); fails++; end
        tests++;
        tick();
      end
    end
    funct3 = 3'b000; zero = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_jumps_misc;
    logic [6:0]  ops [6];
    logic [14:0] ev  [6][6];
    int          len [6];
    ops = '{7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0010011, 7'b0100011};
    ev[0] = '{E_FETCH1, E_DECODE, E_JALR, E_JLINK, E_ALUWB, E_FETCH1};
    ev[1] = '{E_FETCH1, E_DECODE, E_JAL, E_ALUWB, E_FETCH1, E_DECODE};
    ev[2] = '{E_FETCH1, E_DECODE, E_LUI, E_FETCH1, E_DECODE, E_LUI};
    ev[3] = '{E_FETCH1, E_DECODE, E_ALUWB, E_FETCH1, E_DECODE, E_ALUWB};
    ev[4] = '{E_FETCH1, E_DECODE, E_EXECI, E_ALUWB, E_FETCH1, E_DECODE};
    ev[5] = '{E_FETCH1, E_DECODE, E_MEMADR, E_MEMWRITE, E_FETCH1, E_DECODE};
    len = '{6, 6, 6, 6, 6, 6};
    mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      opcode = ops[k];
      do_reset();
      for (int i = 0; i < len[k]; i++) begin
        #1;
        if (obs !== ev[k][i]) begin
          $display("FAIL seq op=%b cyc%0d: got %b want %b", ops[k], i, obs, ev[k][i]); fails++;
        end
        tests++;
        tick();
      end
    end
  endtask

  task automatic test_trap;
    do_reset();
    opcode = 7'b0000000;
    mem_ready = 1'b1;
    #1;
    if (obs !== E_FETCH1) begin $display("FAIL trap_fetch: got %b want %b", obs, E_FETCH1); fails++; end
    tests++;
    tick();
    if (obs !== E_DECODE) begin $display("FAIL trap_decode: got %b want %b", obs, E_DECODE); fails++; end
    tests++;
    tick();
    opcode = 7'b0110011;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (obs !== E_TRAP) begin $display("FAIL trap_sticky cyc%0d: got %b want %b", i, obs, E_TRAP); fails++; end
      tests++;
      tick();
    end
    reset = 1'b1;
    #1;
    if (obs !== E_ZERO) begin $display("FAIL trap_reset_outs: got %b want %b", obs, E_ZERO); fails++; end
    tests++;
    tick();
    reset = 1'b0;
    #1;
    if (obs !== E_FETCH1) begin $display("FAIL trap_exit: got %b want %b", obs, E_FETCH1); fails++; end
    tests++;
  endtask

  task automatic test_reset_midwrite;
    logic [14:0] ev  [5];
    logic        rdy [5];
    ev  = '{E_FETCH1, E_DECODE, E_MEMADR, E_MEMWRITE, E_MEMWRITE};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      if (obs !== ev[i]) begin $display("FAIL sw_wait cyc%0d: got %b want %b", i, obs, ev[i]); fails++; end
      tests++;
      tick();
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    if (mem_write !== 1'b0) begin $display("FAIL sw_reset_mem_write: got %b want 0", mem_write); fails++; end
    tests++;
    if (obs !== E_ZERO) begin $display("FAIL sw_reset_outs: got %b want %b", obs, E_ZERO); fails++; end
    tests++;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    if (obs !== E_FETCH1) begin $display("FAIL sw_reset_fetch: got %b want %b", obs, E_FETCH1); fails++; end
    tests++;
  endtask

  task automatic test_nowait;
    logic [14:0] ev [5];
    ev = '{E_FETCH1, E_DECODE, E_MEMADR, E_MEMWRITE, E_FETCH1};
    opcode = 7'b0100011;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (obs0 !== ev[i]) begin $display("FAIL nowait_sw cyc%0d: got %b want %b", i, obs0, ev[i]); fails++; end
      tests++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jumps_misc();
    test_trap();
    test_reset_midwrite();
    test_nowait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
